// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline control outputs of the CPU pipeline sequencer.
// The master side raises hazards and memory requests; the slave side is the sequencer.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             load_use_i;
  logic             branch_i;
  logic             jump_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_write_o;
  logic             ifid_hold_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             stall_all_o;
  logic             err_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output load_use_i, branch_i, jump_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o,
    input  stall_all_o, err_o, state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  load_use_i, branch_i, jump_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o,
    output stall_all_o, err_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates memory freeze, load-use bubble and ID-stage flush,
// with a miss watchdog and saturating stall/flush event counters.
module pipe_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic      clk_i,
  input  logic      rst_i,
  pipe_ctrl_if.slave pc
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              mstall;
  logic              pc_write, ifid_hold, ifid_flush, idex_bubble, stall_all;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (stall_all || idex_bubble) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (ifid_flush)               flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    err_d       = err_q;
    mstall      = 1'b0;
    pc_write    = 1'b1;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_all   = 1'b0;

    unique case (state_q)
      RUN: begin
        mstall = pc.mem_req_i & ~pc.mem_ack_i;
        if (mstall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        mstall = ~pc.mem_ack_i;
        if (pc.mem_ack_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: mstall = 1'b1;  // ERR: frozen until reset, late acks ignored
    endcase

    // Priority: reset freeze, memory freeze, load-use bubble, ID-stage flush
    if (rst_i || mstall) begin
      stall_all = 1'b1;
      pc_write  = 1'b0;
      ifid_hold = 1'b1;
    end else if (pc.load_use_i) begin
      pc_write    = 1'b0;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else if (pc.branch_i || pc.jump_i) begin
      ifid_flush = 1'b1;
    end
  end

  assign pc.pc_write_o    = pc_write;
  assign pc.ifid_hold_o   = ifid_hold;
  assign pc.ifid_flush_o  = ifid_flush;
  assign pc.idex_bubble_o = idex_bubble;
  assign pc.stall_all_o   = stall_all;
  assign pc.err_o         = err_q;
  assign pc.state_o       = state_q;
  assign pc.stall_cnt_o   = stall_cnt_q;
  assign pc.flush_cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one default instance and one with TIMEOUT=4, CNT_W=3.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) a_if ();
  pipe_ctrl_if #(.CNT_W(3))  b_if ();

  pipe_ctrl #(.CNT_W(16), .TIMEOUT(64)) u_a (.clk_i(clk), .rst_i(rst), .pc(a_if));
  pipe_ctrl #(.CNT_W(3),  .TIMEOUT(4))  u_b (.clk_i(clk), .rst_i(rst), .pc(b_if));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {stall_all, pc_write, ifid_hold, ifid_flush, idex_bubble}
  function automatic logic [31:0] ctl_a();
    return 32'({a_if.stall_all_o, a_if.pc_write_o, a_if.ifid_hold_o,
                a_if.ifid_flush_o, a_if.idex_bubble_o});
  endfunction

  function automatic logic [31:0] ctl_b();
    return 32'({b_if.stall_all_o, b_if.pc_write_o, b_if.ifid_hold_o,
                b_if.ifid_flush_o, b_if.idex_bubble_o});
  endfunction

  task automatic drive_a(input logic lu, br, jp, rq, ak);
    a_if.load_use_i = lu; a_if.branch_i = br; a_if.jump_i = jp;
    a_if.mem_req_i  = rq; a_if.mem_ack_i = ak;
  endtask

  task automatic drive_b(input logic lu, br, jp, rq, ak);
    b_if.load_use_i = lu; b_if.branch_i = br; b_if.jump_i = jp;
    b_if.mem_req_i  = rq; b_if.mem_ack_i = ak;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] C_IDLE   = 32'b01000;
  localparam logic [31:0] C_FREEZE = 32'b10100;
  localparam logic [31:0] C_BUBBLE = 32'b00101;
  localparam logic [31:0] C_FLUSH  = 32'b01010;

  initial begin
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    tick();
    tick();
    check("rst_ctl", ctl_a(), C_FREEZE);
    check("rst_state", 32'(a_if.state_o), 32'd0);
    check("rst_stall_cnt", 32'(a_if.stall_cnt_o), 32'd0);

    // Reset pulsed in the middle of a miss
    rst = 1'b0;
    #1;
    check("idle_ctl", ctl_a(), C_IDLE);
    drive_a(0, 0, 0, 1, 0);
    #1;
    check("miss_ctl", ctl_a(), C_FREEZE);
    tick();
    check("miss_state", 32'(a_if.state_o), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("async_rst_state", 32'(a_if.state_o), 32'd0);
    check("async_rst_ctl", ctl_a(), C_FREEZE);
    check("async_rst_cnt", 32'(a_if.stall_cnt_o), 32'd0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ctl", ctl_a(), C_IDLE);
    check("post_rst_err", 32'(a_if.err_o), 32'd0);
    check("post_rst_flush_cnt", 32'(a_if.flush_cnt_o), 32'd0);

    // Single load-use bubble
    drive_a(1, 0, 0, 0, 0);
    #1;
    check("lu_ctl", ctl_a(), C_BUBBLE);
    tick();
    check("lu_stall_cnt", 32'(a_if.stall_cnt_o), 32'd1);
    drive_a(0, 0, 0, 0, 0);
    #1;
    check("lu_after_ctl", ctl_a(), C_IDLE);

    // Five-cycle miss, ack on the sixth cycle
    drive_a(0, 0, 0, 1, 0);
    #1;
    check("m5_c1_state", 32'(a_if.state_o), 32'd0);
    check("m5_c1_ctl", ctl_a(), C_FREEZE);
    tick();
    for (int i = 2; i <= 5; i++) begin
      check("m5_wait_state", 32'(a_if.state_o), 32'd1);
      check("m5_wait_stall", 32'(a_if.stall_all_o), 32'd1);
      tick();
    end
    drive_a(0, 0, 0, 1, 1);
    #1;
    check("m5_ack_state", 32'(a_if.state_o), 32'd1);
    check("m5_ack_ctl", ctl_a(), C_IDLE);
    tick();
    drive_a(0, 0, 0, 0, 0);
    check("m5_done_state", 32'(a_if.state_o), 32'd0);
    check("m5_stall_cnt", 32'(a_if.stall_cnt_o), 32'd6);

    // Hit acked in the same cycle costs nothing
    drive_a(0, 0, 0, 1, 1);
    #1;
    check("hit_ctl", ctl_a(), C_IDLE);
    tick();
    drive_a(0, 0, 0, 0, 0);
    check("hit_state", 32'(a_if.state_o), 32'd0);
    check("hit_stall_cnt", 32'(a_if.stall_cnt_o), 32'd6);

    // Branch held through a three-cycle miss
    drive_a(0, 1, 0, 1, 0);
    #1;
    check("bm_c1_ctl", ctl_a(), C_FREEZE);
    tick();
    check("bm_c2_ctl", ctl_a(), C_FREEZE);
    tick();
    check("bm_c3_ctl", ctl_a(), C_FREEZE);
    tick();
    drive_a(0, 1, 0, 1, 1);
    #1;
    check("bm_ack_ctl", ctl_a(), C_FLUSH);
    tick();
    drive_a(0, 0, 0, 0, 0);
    check("bm_flush_cnt", 32'(a_if.flush_cnt_o), 32'd1);
    check("bm_stall_cnt", 32'(a_if.stall_cnt_o), 32'd9);

    // Load-use beats branch: bubble only, no flush counted
    drive_a(1, 1, 0, 0, 0);
    #1;
    check("lub_ctl", ctl_a(), C_BUBBLE);
    tick();
    drive_a(0, 0, 0, 0, 0);
    check("lub_flush_cnt", 32'(a_if.flush_cnt_o), 32'd1);
    check("lub_stall_cnt", 32'(a_if.stall_cnt_o), 32'd10);

    // Branch and jump together are one flush
    drive_a(0, 1, 1, 0, 0);
    #1;
    check("bj_ctl", ctl_a(), C_FLUSH);
    tick();
    drive_a(0, 0, 0, 0, 0);
    check("bj_flush_cnt", 32'(a_if.flush_cnt_o), 32'd2);

    // Watchdog on the TIMEOUT=4 instance
    drive_b(0, 0, 0, 1, 0);
    #1;
    check("to_c1_state", 32'(b_if.state_o), 32'd0);
    tick();
    for (int i = 2; i <= 5; i++) begin
      check("to_wait_state", 32'(b_if.state_o), 32'd1);
      check("to_wait_err", 32'(b_if.err_o), 32'd0);
      tick();
    end
    check("to_err_state", 32'(b_if.state_o), 32'd2);
    check("to_err_flag", 32'(b_if.err_o), 32'd1);
    check("to_err_ctl", ctl_b(), C_FREEZE);
    drive_b(0, 0, 0, 1, 1);
    #1;
    check("to_late_ack_ctl", ctl_b(), C_FREEZE);
    tick();
    drive_b(0, 0, 0, 0, 0);
    tick();
    check("to_sticky_state", 32'(b_if.state_o), 32'd2);
    check("to_sticky_err", 32'(b_if.err_o), 32'd1);
    check("to_sat_cnt", 32'(b_if.stall_cnt_o), 32'd7);
    rst = 1'b1;
    #1;
    check("to_rst_state", 32'(b_if.state_o), 32'd0);
    check("to_rst_err", 32'(b_if.err_o), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("to_rst_cnt", 32'(b_if.stall_cnt_o), 32'd0);

    // Counter saturation at 7 with CNT_W=3
    drive_b(1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("sat_stall_cnt", 32'(b_if.stall_cnt_o), (i > 7) ? 32'd7 : 32'(i));
    end
    drive_b(0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU.
- Drives the hold, flush and global-stall controls of the PC, the IF/ID register and the ID/EX register.
- Arbitrates three hazard sources:
  - load-use data hazard (single bubble);
  - taken branch/jump resolved in ID (IF flush);
  - multi-cycle data-cache access in MEM (global freeze with watchdog).
- Keeps saturating performance counters for stall and flush events.

Parameters:
CNT_W, 16, width of stall_cnt_o and flush_cnt_o
TIMEOUT, 64, max cycles in MEM_WAIT before error (must be >= 2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous active-high reset
load_use_i  in  1  ID/EX holds a load whose rt matches the rs/rt of the instruction in ID
branch_i  in  1  branch in ID resolved taken
jump_i  in  1  jump decoded in ID
mem_req_i  in  1  MEM stage issuing a data-cache access this cycle (held until acked)
mem_ack_i  in  1  data cache completes the access this cycle
pc_write_o  out  1  1 = PC loads next value
ifid_hold_o  out  1  1 = IF/ID keeps contents (write inhibit)
ifid_flush_o  out  1  1 = IF/ID loads a NOP (32'b0) instead of the fetched instruction
idex_bubble_o  out  1  1 = ID/EX control fields zeroed (bubble)
stall_all_o  out  1  1 = every pipeline register and the PC frozen
err_o  out  1  sticky memory-timeout error
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR
stall_cnt_o  out  CNT_W  cycles with any stall, saturating
flush_cnt_o  out  CNT_W  applied flushes, saturating

Behaviour:
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: cache miss in flight.
  - ERR: watchdog fired.
- Registered state: state, wait counter (ceil(log2(TIMEOUT+1)) bits), err_o, the two counters.
- Control outputs are combinational from state and inputs, so each takes effect in the same cycle.
- While rst_i = 1 (asynchronous):
  - state = RUN, wait counter = 0, err_o = 0, both counters = 0.
  - Forced outputs: stall_all_o = 1, pc_write_o = 0, ifid_hold_o = 1, ifid_flush_o = 0, idex_bubble_o = 0.
- Memory stall (highest priority). Define mstall:
  - RUN: mstall = mem_req_i & ~mem_ack_i.
  - MEM_WAIT: mstall = ~mem_ack_i.
  - ERR: mstall = 1.
  - stall_all_o = mstall. When mstall = 1: pc_write_o = 0, ifid_hold_o = 1, ifid_flush_o = 0, idex_bubble_o = 0.
  - A hit acked in the same cycle (mem_req_i & mem_ack_i in RUN) costs zero cycles.
- Transitions:
  - RUN -> MEM_WAIT when mem_req_i & ~mem_ack_i; wait counter loads 1.
  - MEM_WAIT -> RUN on mem_ack_i. In that cycle stall_all_o = 0 and load-use/branch logic applies normally.
  - Otherwise in MEM_WAIT the wait counter increments.
  - MEM_WAIT -> ERR when the wait counter = TIMEOUT and no ack; err_o set to 1.
  - ERR is terminal until reset. A late mem_ack_i is ignored.
- Load-use (only when mstall = 0):
  - load_use_i = 1 gives pc_write_o = 0, ifid_hold_o = 1, idex_bubble_o = 1, ifid_flush_o = 0.
  - This costs one bubble per asserted cycle; the upstream hazard unit deasserts it once the load moves to MEM.
- Flush (only when mstall = 0 and load_use_i = 0):
  - branch_i | jump_i gives ifid_flush_o = 1, pc_write_o = 1, ifid_hold_o = 0, idex_bubble_o = 0.
  - Branch and jump together count as one flush.
  - When load_use_i is also asserted, load-use wins: the branch operands are not yet valid, so the flush is not applied and not counted.
  - When mstall = 1, the flush is suppressed. Inputs stay stable because the pipeline is frozen, so the flush applies on the first unstalled cycle.
- Default (no event): pc_write_o = 1, all other controls 0.
- Counters:
  - stall_cnt_o increments in each cycle where stall_all_o = 1 or idex_bubble_o = 1.
  - flush_cnt_o increments in each cycle where ifid_flush_o = 1.
  - Both saturate at 2^CNT_W - 1 (no wrap). Neither counts during reset.

Test Plan:
- Reset then idle inputs: rst_i pulsed mid-MEM_WAIT -> immediately state_o = 0, stall_all_o = 1 while rst_i high; after release pc_write_o = 1, counters 0, err_o = 0.
- Load-use: load_use_i high 1 cycle -> that cycle pc_write_o = 0, ifid_hold_o = 1, idex_bubble_o = 1; stall_cnt_o = 1; next cycle pc_write_o = 1.
- Miss of 5 cycles: mem_req_i high, mem_ack_i on the 6th cycle -> stall_all_o = 1 for 5 cycles, state_o = 1 for cycles 2-6, 0 on the ack cycle edge; stall_cnt_o = 5. Also: hit with same-cycle ack -> no stall, count unchanged.
- Branch during miss, then load-use plus branch together: branch_i held through a 3-cycle miss -> ifid_flush_o = 0 while stalled, 1 on the ack cycle, flush_cnt_o = 1. Then load_use_i and branch_i both high -> bubble only, flush_cnt_o unchanged.
- Timeout with TIMEOUT = 4: mem_req_i held, never acked -> state_o = 2 and err_o = 1 after 4 wait cycles; stall_all_o stays 1; later mem_ack_i ignored; only reset clears.
- Saturation with CNT_W = 3: 10 load-use cycles -> stall_cnt_o stops at 7.
